// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A interrupt-acknowledge sequencer.
package pic_pkg;

    localparam int VECTOR_W = 8;
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;
    localparam int ICW4_AEOI_BIT = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ACK1  = 3'd2,
        WAIT2 = 3'd3,
        ACK2  = 3'd4
    } seqStateT;

    // Every registered output plus the latched spurious flag, so one reset constant covers all of them.
    typedef struct packed {
        logic                intOut;
        logic                freezeIrr;
        logic                isrSet;
        logic                isrAeoiClr;
        logic [2:0]          isrIndex;
        logic [VECTOR_W-1:0] vectorOut;
        logic                vectorOe;
        logic                ackAbort;
        logic                spurious;
    } seqRegsT;

    localparam seqRegsT SEQ_REGS_RESET = '0;

    function automatic logic [VECTOR_W-1:0] makeVector(input logic [4:0] base, input logic [2:0] level);
        return {base, level};
    endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// Signal bundle between the sequencer and the resolver / ISR / data-bus buffer / CPU side.
interface inta_sequencer_if;
    import pic_pkg::*;

    logic                initDone;
    logic                irqPending;
    logic [2:0]          irqIndex;
    logic                intaN;
    logic [4:0]          icw2Base;
    logic                icw4Aeoi;

    logic                intOut;
    logic                freezeIrr;
    logic                isrSet;
    logic                isrAeoiClr;
    logic [2:0]          isrIndex;
    logic [VECTOR_W-1:0] vectorOut;
    logic                vectorOe;
    logic                ackAbort;

    modport master (
        input  initDone, irqPending, irqIndex, intaN, icw2Base, icw4Aeoi,
        output intOut, freezeIrr, isrSet, isrAeoiClr, isrIndex, vectorOut, vectorOe, ackAbort
    );

    modport slave (
        output initDone, irqPending, irqIndex, intaN, icw2Base, icw4Aeoi,
        input  intOut, freezeIrr, isrSet, isrAeoiClr, isrIndex, vectorOut, vectorOe, ackAbort
    );

endinterface

// File: rtl/inta_edge_det.sv
// Edge detector for the already-synchronous INTA strobe; intaPrev idles high like the pin.
module inta_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic intaN,
    output logic fall,
    output logic rise
);

    logic intaPrev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            intaPrev <= 1'b1;
        end else begin
            intaPrev <= intaN;
        end
    end

    assign fall = intaPrev & ~intaN;
    assign rise = ~intaPrev & intaN;

endmodule

// File: rtl/inta_sequencer.sv
// 8086-mode INTA sequencer: raises INT, sets the ISR bit on the first INTA pulse,
// drives the vector on the second, and aborts if the second pulse never comes.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    inta_sequencer_if.master  bus
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_COUNT = CNT_W'(ACK_TIMEOUT);

    seqStateT         state;
    seqStateT         stateNext;
    seqRegsT          regs;
    seqRegsT          regsNext;
    logic [CNT_W-1:0] ackCount;
    logic [CNT_W-1:0] ackCountNext;
    logic             intaFall;
    logic             intaRise;
    logic             timeoutHit;

    inta_edge_det edgeDet (
        .clk   (clk),
        .rst_n (rst_n),
        .intaN (bus.intaN),
        .fall  (intaFall),
        .rise  (intaRise)
    );

    // Abort on the edge where the count would reach ACK_TIMEOUT, so WAIT2 lasts exactly ACK_TIMEOUT clocks.
    assign timeoutHit = (ackCount + CNT_W'(1)) == TIMEOUT_COUNT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            regs     <= SEQ_REGS_RESET;
            ackCount <= '0;
        end else begin
            state    <= stateNext;
            regs     <= regsNext;
            ackCount <= ackCountNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (!bus.initDone) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (bus.irqPending) stateNext = REQ;
                REQ:     if (intaFall) stateNext = ACK1;
                ACK1:    if (intaRise) stateNext = WAIT2;
                WAIT2: begin
                    if (intaFall) begin
                        stateNext = ACK2;
                    end else if (timeoutHit) begin
                        stateNext = IDLE;
                    end
                end
                ACK2:    if (intaRise) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        regsNext            = regs;
        regsNext.isrSet     = 1'b0;
        regsNext.isrAeoiClr = 1'b0;
        regsNext.ackAbort   = 1'b0;
        ackCountNext        = ackCount;
        if (!bus.initDone) begin
            regsNext     = SEQ_REGS_RESET;
            ackCountNext = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.irqPending) regsNext.intOut = 1'b1;
                end
                REQ: begin
                    // A request withdrawn before the first INTA is acknowledged as level 7 without touching the ISR.
                    if (intaFall) begin
                        regsNext.intOut    = 1'b0;
                        regsNext.freezeIrr = 1'b1;
                        regsNext.isrIndex  = bus.irqPending ? bus.irqIndex : SPURIOUS_LEVEL;
                        regsNext.isrSet    = bus.irqPending;
                        regsNext.spurious  = ~bus.irqPending;
                    end
                end
                ACK1: begin
                    ackCountNext = '0;
                end
                WAIT2: begin
                    if (intaFall) begin
                        regsNext.vectorOe  = 1'b1;
                        regsNext.vectorOut = makeVector(bus.icw2Base, regs.isrIndex);
                    end else if (timeoutHit) begin
                        regsNext.ackAbort  = 1'b1;
                        regsNext.freezeIrr = 1'b0;
                    end else begin
                        ackCountNext = ackCount + CNT_W'(1);
                    end
                end
                ACK2: begin
                    if (intaRise) begin
                        regsNext.vectorOe   = 1'b0;
                        regsNext.freezeIrr  = 1'b0;
                        regsNext.isrAeoiClr = bus.icw4Aeoi & ~regs.spurious;
                    end else begin
                        regsNext.vectorOut = makeVector(bus.icw2Base, regs.isrIndex);
                    end
                end
                default: regsNext = SEQ_REGS_RESET;
            endcase
        end
    end

    assign bus.intOut     = regs.intOut;
    assign bus.freezeIrr  = regs.freezeIrr;
    assign bus.isrSet     = regs.isrSet;
    assign bus.isrAeoiClr = regs.isrAeoiClr;
    assign bus.isrIndex   = regs.isrIndex;
    assign bus.vectorOut  = regs.vectorOut;
    assign bus.vectorOe   = regs.vectorOe;
    assign bus.ackAbort   = regs.ackAbort;

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: each driven cycle queues the outputs expected after its clock edge.
module tb_inta_sequencer;
    import pic_pkg::*;

    typedef struct packed {
        logic       intOut;
        logic       freezeIrr;
        logic       isrSet;
        logic       isrAeoiClr;
        logic [2:0] isrIndex;
        logic [7:0] vectorOut;
        logic       vectorOe;
        logic       ackAbort;
    } expT;

    logic       clk;
    logic       rst_n;
    logic       rstV;
    logic       initV;
    logic       pendV;
    logic [2:0] idxV;
    logic [4:0] baseV;
    logic       aeoiV;
    logic [7:0] icw4Byte;
    logic [2:0] lastIdx;
    logic [7:0] lastVec;
    int         testsRun;
    int         testsFailed;
    string      tagQ[$];
    expT        expQ[$];

    inta_sequencer_if bus ();

    inta_sequencer #(.ACK_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic expT mkExp(input logic io, input logic fr, input logic set, input logic clr,
                                  input logic [2:0] idx, input logic [7:0] vec, input logic oe, input logic ab);
        expT e;
        e.intOut     = io;
        e.freezeIrr  = fr;
        e.isrSet     = set;
        e.isrAeoiClr = clr;
        e.isrIndex   = idx;
        e.vectorOut  = vec;
        e.vectorOe   = oe;
        e.ackAbort   = ab;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic inta, input expT e);
        @(negedge clk);
        rst_n          = rstV;
        bus.initDone   = initV;
        bus.irqPending = pendV;
        bus.irqIndex   = idxV;
        bus.intaN      = inta;
        bus.icw2Base   = baseV;
        bus.icw4Aeoi   = aeoiV;
        tagQ.push_back(tag);
        expQ.push_back(e);
    endtask

    // Outputs settle just after the rising edge; compare every field of the oldest queued expectation.
    always @(posedge clk) begin
        string tag;
        expT   e;
        #1;
        if (expQ.size() > 0) begin
            tag = tagQ.pop_front();
            e   = expQ.pop_front();
            checkOutput({tag, ".intOut"},     32'(bus.intOut),     32'(e.intOut));
            checkOutput({tag, ".freezeIrr"},  32'(bus.freezeIrr),  32'(e.freezeIrr));
            checkOutput({tag, ".isrSet"},     32'(bus.isrSet),     32'(e.isrSet));
            checkOutput({tag, ".isrAeoiClr"}, 32'(bus.isrAeoiClr), 32'(e.isrAeoiClr));
            checkOutput({tag, ".isrIndex"},   32'(bus.isrIndex),   32'(e.isrIndex));
            checkOutput({tag, ".vectorOut"},  32'(bus.vectorOut),  32'(e.vectorOut));
            checkOutput({tag, ".vectorOe"},   32'(bus.vectorOe),   32'(e.vectorOe));
            checkOutput({tag, ".ackAbort"},   32'(bus.ackAbort),   32'(e.ackAbort));
        end
    end

    // Full two-pulse acknowledge; midLevel replaces irqIndex between the pulses, withdraw drops irqPending before INTA.
    task automatic runAck(input string tag, input logic [2:0] level, input logic [2:0] midLevel,
                          input logic withdraw, input logic aeoi);
        logic [2:0] idxExp;
        logic [7:0] vecExp;
        idxExp = withdraw ? 3'd7 : level;
        vecExp = {baseV, idxExp};
        aeoiV  = aeoi;
        pendV  = 1'b1;
        idxV   = level;
        applyStimulus({tag, ":int"}, 1'b1, mkExp(1'b1, 1'b0, 1'b0, 1'b0, lastIdx, lastVec, 1'b0, 1'b0));
        if (withdraw) pendV = 1'b0;
        applyStimulus({tag, ":req"}, 1'b1, mkExp(1'b1, 1'b0, 1'b0, 1'b0, lastIdx, lastVec, 1'b0, 1'b0));
        applyStimulus({tag, ":inta1"}, 1'b0, mkExp(1'b0, 1'b1, !withdraw, 1'b0, idxExp, lastVec, 1'b0, 1'b0));
        pendV = 1'b0;
        applyStimulus({tag, ":ack1"}, 1'b0, mkExp(1'b0, 1'b1, 1'b0, 1'b0, idxExp, lastVec, 1'b0, 1'b0));
        idxV = midLevel;
        applyStimulus({tag, ":rise1"}, 1'b1, mkExp(1'b0, 1'b1, 1'b0, 1'b0, idxExp, lastVec, 1'b0, 1'b0));
        applyStimulus({tag, ":wait2"}, 1'b1, mkExp(1'b0, 1'b1, 1'b0, 1'b0, idxExp, lastVec, 1'b0, 1'b0));
        applyStimulus({tag, ":inta2"}, 1'b0, mkExp(1'b0, 1'b1, 1'b0, 1'b0, idxExp, vecExp, 1'b1, 1'b0));
        applyStimulus({tag, ":ack2"}, 1'b0, mkExp(1'b0, 1'b1, 1'b0, 1'b0, idxExp, vecExp, 1'b1, 1'b0));
        applyStimulus({tag, ":rise2"}, 1'b1, mkExp(1'b0, 1'b0, 1'b0, aeoi && !withdraw, idxExp, vecExp, 1'b0, 1'b0));
        applyStimulus({tag, ":idle"}, 1'b1, mkExp(1'b0, 1'b0, 1'b0, 1'b0, idxExp, vecExp, 1'b0, 1'b0));
        lastIdx = idxExp;
        lastVec = vecExp;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clk            = 1'b0;
        rst_n          = 1'b0;
        testsRun       = 0;
        testsFailed    = 0;
        rstV           = 1'b0;
        initV          = 1'b1;
        pendV          = 1'b0;
        idxV           = 3'd0;
        baseV          = 5'b11101;
        icw4Byte       = 8'h00;
        aeoiV          = icw4Byte[ICW4_AEOI_BIT];
        lastIdx        = 3'd0;
        lastVec        = 8'h00;
        bus.initDone   = 1'b1;
        bus.irqPending = 1'b0;
        bus.irqIndex   = 3'd0;
        bus.intaN      = 1'b1;
        bus.icw2Base   = baseV;
        bus.icw4Aeoi   = 1'b0;

        applyStimulus("reset0", 1'b1, mkExp(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
        applyStimulus("reset1", 1'b1, mkExp(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
        rstV = 1'b1;

        runAck("ir3", 3'd3, 3'd3, 1'b0, 1'b0);
        icw4Byte = 8'h02;
        runAck("aeoi", 3'd3, 3'd3, 1'b0, icw4Byte[ICW4_AEOI_BIT]);
        runAck("spur", 3'd4, 3'd4, 1'b1, 1'b1);
        runAck("idxHold", 3'd5, 3'd1, 1'b0, 1'b0);

        aeoiV = 1'b0;
        pendV = 1'b1;
        idxV  = 3'd2;
        applyStimulus("tmo:int", 1'b1, mkExp(1'b1, 1'b0, 1'b0, 1'b0, lastIdx, lastVec, 1'b0, 1'b0));
        applyStimulus("tmo:inta1", 1'b0, mkExp(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, lastVec, 1'b0, 1'b0));
        pendV = 1'b0;
        applyStimulus("tmo:rise1", 1'b1, mkExp(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, lastVec, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus("tmo:wait2", 1'b1, mkExp(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, lastVec, 1'b0, 1'b0));
        end
        applyStimulus("tmo:abort", 1'b1, mkExp(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, lastVec, 1'b0, 1'b1));
        applyStimulus("tmo:idle", 1'b1, mkExp(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, lastVec, 1'b0, 1'b0));
        lastIdx = 3'd2;

        pendV = 1'b1;
        idxV  = 3'd4;
        applyStimulus("drop:int", 1'b1, mkExp(1'b1, 1'b0, 1'b0, 1'b0, lastIdx, lastVec, 1'b0, 1'b0));
        applyStimulus("drop:inta1", 1'b0, mkExp(1'b0, 1'b1, 1'b1, 1'b0, 3'd4, lastVec, 1'b0, 1'b0));
        pendV = 1'b0;
        applyStimulus("drop:rise1", 1'b1, mkExp(1'b0, 1'b1, 1'b0, 1'b0, 3'd4, lastVec, 1'b0, 1'b0));
        initV = 1'b0;
        applyStimulus("drop:init0", 1'b1, mkExp(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
        initV   = 1'b1;
        lastIdx = 3'd0;
        lastVec = 8'h00;
        runAck("reinit", 3'd6, 3'd6, 1'b0, 1'b0);

        pendV = 1'b1;
        idxV  = 3'd1;
        applyStimulus("rst:int", 1'b1, mkExp(1'b1, 1'b0, 1'b0, 1'b0, lastIdx, lastVec, 1'b0, 1'b0));
        applyStimulus("rst:inta1", 1'b0, mkExp(1'b0, 1'b1, 1'b1, 1'b0, 3'd1, lastVec, 1'b0, 1'b0));
        pendV = 1'b0;
        applyStimulus("rst:rise1", 1'b1, mkExp(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, lastVec, 1'b0, 1'b0));
        applyStimulus("rst:inta2", 1'b0, mkExp(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'hE9, 1'b1, 1'b0));
        rstV = 1'b0;
        applyStimulus("rst:assert", 1'b0, mkExp(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
        rstV = 1'b1;
        applyStimulus("rst:release", 1'b1, mkExp(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
        lastIdx = 3'd0;
        lastVec = 8'h00;
        runAck("afterRst", 3'd3, 3'd3, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #2;
        checkOutput("drain", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
